// File: rtl/dwt_pkg.sv
// Shared constants and state encoding for the LeGall 5/3 lifting MAC.
//   PIX_W         pixel width
//   D_W           signed width of the detail coefficient d[n]
//   S_W           signed width of the approx coefficient s[n]
//   DETAIL_OFFSET bias added to d[n] so it fits an unsigned pixel
//   state_t       IDLE (nothing held), PEND (pair held), FLUSH (emit last pair of line)
package dwt_pkg;
    localparam int PIX_W         = 8;
    localparam int D_W           = 10;
    localparam int S_W           = 11;
    localparam int DETAIL_OFFSET = 128;

    typedef enum logic [1:0] {IDLE, PEND, FLUSH} state_t;
endpackage

// File: rtl/dwt_clamp8.sv
// Reduces a signed S_W-bit coefficient to an 8-bit pixel.
//   x  in  S_W signed coefficient
//   y  out 8-bit result
// Macro DWT_SATURATE_EN: clamp to [0,255]; undefined: keep the low 8 bits (wrap).
module dwt_clamp8
    import dwt_pkg::*;
(
    input  logic signed [S_W-1:0]   x,
    output logic        [PIX_W-1:0] y
);
    always_comb begin
`ifdef DWT_SATURATE_EN
        if (x < 0)
            y = '0;
        else if (x > 11'sd255)
            y = '1;
        else
            y = x[PIX_W-1:0];
`else
        y = x[PIX_W-1:0];
`endif
    end
endmodule

// File: rtl/lifting_53_mac.sv
// LeGall 5/3 integer lifting responder for the 2-D DWT controller.
// Takes {even,odd} pixel pairs of a line and returns {approx, detail+128}
// for each pair, tagged with the pair's pointers, in input order.
//   clk, rst                  clock, asynchronous active-high reset
//   i_mac                     [15:8] even e[n], [7:0] odd o[n]
//   i_mac_valid               pair valid (no backpressure)
//   i_mac_row_column_pointer  line index of the pair
//   i_mac_pixel_pointer       even pixel index of the pair
//   i_line_end                pair is the last of its line
//   o_mac                     [15:8] s[n], [7:0] d[n]+128
//   o_mac_valid               result valid (one cycle per result)
//   o_mac_row_column_pointer  pointers of the emitted pair
//   o_mac_pixel_pointer
// Macro DWT_SATURATE_EN selects clamping instead of wrap in dwt_clamp8.
module lifting_53_mac
    import dwt_pkg::*;
#(
    parameter  int WIDTH  = 256,
    parameter  int HEIGHT = 256,
    localparam int PW     = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   i_mac,
    input  logic          i_mac_valid,
    input  logic [PW-1:0] i_mac_row_column_pointer,
    input  logic [PW-1:0] i_mac_pixel_pointer,
    input  logic          i_line_end,
    output logic [15:0]   o_mac,
    output logic          o_mac_valid,
    output logic [PW-1:0] o_mac_row_column_pointer,
    output logic [PW-1:0] o_mac_pixel_pointer
);
    if (HEIGHT > WIDTH) begin : g_bad_height
        $error("HEIGHT must not exceed WIDTH");
    end

    state_t               state, state_nx;
    logic [PIX_W-1:0]     held_e, held_o;
    logic [PW-1:0]        held_rc, held_px;
    logic                 line_first;
    logic signed [D_W-1:0] d_prev;

    logic [PIX_W-1:0]      e_next;
    logic [PIX_W:0]        e_sum;
    logic signed [D_W-1:0] d_cur, d_left;
    logic signed [S_W-1:0] s_sum, s_cur, d_off;
    logic [PIX_W-1:0]      s_pix, d_pix;
    logic                  emit;

    always_comb begin
        // Right neighbour of the held pair: the incoming even pixel, or the
        // held even pixel itself at the line end (symmetric extension).
        e_next = (state == FLUSH) ? held_e : i_mac[15:8];
        e_sum  = {1'b0, held_e} + {1'b0, e_next};
        d_cur  = $signed({{(D_W-PIX_W){1'b0}}, held_o})
               - $signed({{(D_W-PIX_W+1){1'b0}}, e_sum[PIX_W:1]});
        // Line-first pair has no left detail: mirror d[0].
        d_left = line_first ? d_cur : d_prev;
        s_sum  = {d_left[D_W-1], d_left} + {d_cur[D_W-1], d_cur} + S_W'(2);
        s_cur  = $signed({{(S_W-PIX_W){1'b0}}, held_e}) + (s_sum >>> 2);
        d_off  = {d_cur[D_W-1], d_cur} + S_W'(DETAIL_OFFSET);
        emit   = (state == FLUSH) || (state == PEND && i_mac_valid);
    end

    always_comb begin
        state_nx = state;
        if (i_mac_valid)
            state_nx = i_line_end ? FLUSH : PEND;
        else if (state == FLUSH)
            state_nx = IDLE;
    end

    dwt_clamp8 u_clamp_s (.x(s_cur), .y(s_pix));
    dwt_clamp8 u_clamp_d (.x(d_off), .y(d_pix));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                    <= IDLE;
            held_e                   <= '0;
            held_o                   <= '0;
            held_rc                  <= '0;
            held_px                  <= '0;
            line_first               <= 1'b0;
            d_prev                   <= '0;
            o_mac                    <= '0;
            o_mac_valid              <= 1'b0;
            o_mac_row_column_pointer <= '0;
            o_mac_pixel_pointer      <= '0;
        end else begin
            state       <= state_nx;
            o_mac_valid <= emit;
            if (emit) begin
                o_mac                    <= {s_pix, d_pix};
                o_mac_row_column_pointer <= held_rc;
                o_mac_pixel_pointer      <= held_px;
                if (state == PEND)
                    d_prev <= d_cur;
            end
            if (i_mac_valid) begin
                held_e     <= i_mac[15:8];
                held_o     <= i_mac[7:0];
                held_rc    <= i_mac_row_column_pointer;
                held_px    <= i_mac_pixel_pointer;
                // Anything arriving outside PEND starts a new line.
                line_first <= (state != PEND);
            end
        end
    end
endmodule

// File: tb/tb_lifting_53_mac.sv
// Self-checking bench for lifting_53_mac: directed lines plus random lines,
// checked against a whole-line array model of the 5/3 lifting equations.
module tb_lifting_53_mac;
    localparam int WIDTH = 256;
    localparam int PW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   i_mac = '0;
    logic          i_mac_valid = 1'b0;
    logic [PW-1:0] i_mac_row_column_pointer = '0;
    logic [PW-1:0] i_mac_pixel_pointer = '0;
    logic          i_line_end = 1'b0;
    logic [15:0]   o_mac;
    logic          o_mac_valid;
    logic [PW-1:0] o_mac_row_column_pointer;
    logic [PW-1:0] o_mac_pixel_pointer;

    lifting_53_mac #(.WIDTH(WIDTH), .HEIGHT(256)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .i_mac                    (i_mac),
        .i_mac_valid              (i_mac_valid),
        .i_mac_row_column_pointer (i_mac_row_column_pointer),
        .i_mac_pixel_pointer      (i_mac_pixel_pointer),
        .i_line_end               (i_line_end),
        .o_mac                    (o_mac),
        .o_mac_valid              (o_mac_valid),
        .o_mac_row_column_pointer (o_mac_row_column_pointer),
        .o_mac_pixel_pointer      (o_mac_pixel_pointer)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] mac;
        logic [7:0]  rc;
        logic [7:0]  px;
    } exp_t;

    exp_t expq[$];
    exp_t mon_ex;
    int   n_chk = 0;
    int   n_pass = 0;
    int   le_e[128];
    int   le_o[128];

`ifdef DWT_SATURATE_EN
    localparam logic [15:0] SINGLE_EXP = 16'h80FF;
`else
    localparam logic [15:0] SINGLE_EXP = 16'h807F;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got %h want %h at %0t", tag, got, exp, $time);
    endtask

    function automatic int fit8(input int x);
`ifdef DWT_SATURATE_EN
        if (x < 0)   return 0;
        if (x > 255) return 255;
        return x;
`else
        return x & 255;
`endif
    endfunction

    // Whole-line lifting: d[k] first for all k, then s[k]; pushes the first
    // nout results of an n-pair line held in le_e/le_o.
    function automatic void model_line(input int n, input int rc, input int nout);
        int d[128];
        int en, dl, s;
        for (int k = 0; k < n; k++) begin
            en   = (k + 1 < n) ? le_e[k+1] : le_e[k];
            d[k] = le_o[k] - ((le_e[k] + en) >>> 1);
        end
        for (int k = 0; k < nout; k++) begin
            exp_t ex;
            dl     = (k == 0) ? d[0] : d[k-1];
            s      = le_e[k] + ((dl + d[k] + 2) >>> 2);
            ex.mac = {8'(fit8(s)), 8'(fit8(d[k] + 128))};
            ex.rc  = 8'(rc);
            ex.px  = 8'(2 * k);
            expq.push_back(ex);
        end
    endfunction

    task automatic send(input int e, input int o, input int rc, input int px, input bit le);
        @(negedge clk);
        i_mac                    = {8'(e), 8'(o)};
        i_mac_valid              = 1'b1;
        i_mac_row_column_pointer = 8'(rc);
        i_mac_pixel_pointer      = 8'(px);
        i_line_end               = le;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_mac_valid = 1'b0;
            i_line_end  = 1'b0;
        end
    endtask

    task automatic run_line(input int n, input int rc, input int gap);
        model_line(n, rc, n);
        for (int k = 0; k < n; k++) begin
            send(le_e[k], le_o[k], rc, 2 * k, k == n - 1);
            idle(gap);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && o_mac_valid) begin
            if (expq.size() == 0) begin
                chk("spurious", 32'd1, 32'd0);
            end else begin
                mon_ex = expq.pop_front();
                chk("mac", 32'(o_mac), 32'(mon_ex.mac));
                chk("rc_ptr", 32'(o_mac_row_column_pointer), 32'(mon_ex.rc));
                chk("px_ptr", 32'(o_mac_pixel_pointer), 32'(mon_ex.px));
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(o_mac_valid), 32'd0);
        chk("rst_mac", 32'(o_mac), 32'd0);
        chk("rst_rc", 32'(o_mac_row_column_pointer), 32'd0);
        chk("rst_px", 32'(o_mac_pixel_pointer), 32'd0);
        rst = 1'b0;
        idle(1);

        // Flat line
        for (int k = 0; k < 4; k++) begin le_e[k] = 100; le_o[k] = 100; end
        run_line(4, 5, 0);
        idle(3);

        // Ramp 0..7
        for (int k = 0; k < 4; k++) begin le_e[k] = 2 * k; le_o[k] = 2 * k + 1; end
        run_line(4, 1, 0);
        idle(3);

        // Single-pair line, with exact two-cycle latency
        le_e[0] = 0; le_o[0] = 255;
        model_line(1, 2, 1);
        send(0, 255, 2, 0, 1'b1);
        idle(1);
        chk("single_lat1", 32'(o_mac_valid), 32'd0);
        idle(1);
        chk("single_lat2", 32'(o_mac_valid), 32'd1);
        chk("single_val", 32'(o_mac), 32'(SINGLE_EXP));
        idle(2);
        le_e[0] = 255; le_o[0] = 0;
        run_line(1, 3, 0);
        idle(3);

        // Back-to-back lines
        for (int k = 0; k < 3; k++) begin le_e[k] = $urandom_range(255); le_o[k] = $urandom_range(255); end
        run_line(3, 10, 0);
        for (int k = 0; k < 2; k++) begin le_e[k] = $urandom_range(255); le_o[k] = $urandom_range(255); end
        run_line(2, 11, 0);
        idle(4);

        // Ramp with gaps
        for (int k = 0; k < 4; k++) begin le_e[k] = 2 * k; le_o[k] = 2 * k + 1; end
        run_line(4, 1, 3);
        idle(3);

        // Reset mid-line: pair 0 emits, pair 1 is discarded
        le_e[0] = 50; le_o[0] = 60; le_e[1] = 70; le_o[1] = 80;
        model_line(2, 20, 1);
        send(50, 60, 20, 0, 1'b0);
        send(70, 80, 20, 2, 1'b0);
        idle(1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(o_mac_valid), 32'd0);
        chk("rst_mid_mac", 32'(o_mac), 32'd0);
        idle(2);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin le_e[k] = 100; le_o[k] = 100; end
        run_line(4, 21, 0);
        idle(3);

        // Random lines, random gaps, some back-to-back
        for (int l = 0; l < 30; l++) begin
            int n;
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) begin
                le_e[k] = $urandom_range(255);
                le_o[k] = $urandom_range(255);
            end
            run_line(n, $urandom_range(255), $urandom_range(0, 2));
            idle($urandom_range(0, 2));
        end

        idle(5);
        chk("drain", 32'(expq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
